// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the program-counter / instruction-fetch controller.
// Holds the address width, reset PC default and the fetch FSM encoding.
package pc_fetch_ctrl_pkg;

    localparam int unsigned ADDR_W = 12;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 12'h000;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/cla_twelve.sv
// 12-bit carry-lookahead adder built from three 4-bit lookahead groups.
// Carry-in is tied low and the carry-out is dropped, so the sum wraps modulo 2^12.
module cla_twelve
    import pc_fetch_ctrl_pkg::*;
(
    input  logic [ADDR_W-1:0] a,
    input  logic [ADDR_W-1:0] b,
    output logic [ADDR_W-1:0] sum
);

    logic              cin;
    logic [10:0]       g;
    logic [ADDR_W-1:0] p;
    logic [ADDR_W-1:0] c;
    logic [1:0]        grp_g;
    logic [1:0]        grp_p;
    logic [2:0]        grp_c;

    assign cin = 1'b0;
    // g[11] would only feed the dropped carry-out
    assign g   = a[10:0] & b[10:0];
    assign p   = a ^ b;

    always_comb begin
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        c     = '0;
        for (int k = 0; k < 2; k++) begin
            grp_g[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end
        grp_c[0] = cin;
        grp_c[1] = grp_g[0] | (grp_p[0] & grp_c[0]);
        grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & grp_c[0]);
        for (int k = 0; k < 3; k++) begin
            c[4*k]   = grp_c[k];
            c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & grp_c[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch controller: req/ack fetch handshake,
// decode stall handling, jump/branch redirect and delivery of fetched PCs.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_offset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] fetched_pc
);

    localparam logic [ADDR_W-1:0] PcStep = 12'd1;

    fetch_state_e      state_q;
    logic              boot_armed_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_pc_inc;
    logic [ADDR_W-1:0] br_target;
    logic              fetch_valid_q;
    logic [ADDR_W-1:0] fetched_pc_q;

    cla_twelve u_pc_inc (
        .a   (pc_q),
        .b   (PcStep),
        .sum (pc_inc)
    );

    cla_twelve u_br_inc (
        .a   (br_pc),
        .b   (PcStep),
        .sum (br_pc_inc)
    );

    // Two's-complement offset needs no sign extension: the wrap does the subtract
    cla_twelve u_br_add (
        .a   (br_pc_inc),
        .b   (br_offset),
        .sum (br_target)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StBoot;
            boot_armed_q  <= 1'b0;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            fetched_pc_q  <= RESET_PC;
        end else begin
            fetch_valid_q <= 1'b0;
            case (state_q)
                // First edge after release arms, second edge starts fetching
                StBoot: begin
                    if (boot_armed_q) begin
                        state_q <= StFetch;
                    end else begin
                        boot_armed_q <= 1'b1;
                    end
                end
                StFetch, StHold: begin
                    if (jump) begin
                        pc_q    <= jump_target;
                        state_q <= StFetch;
                    end else if (branch_taken) begin
                        pc_q    <= br_target;
                        state_q <= StFetch;
                    end else if (state_q == StHold) begin
                        if (!stall) begin
                            fetched_pc_q  <= pc_q;
                            fetch_valid_q <= 1'b1;
                            pc_q          <= pc_inc;
                            state_q       <= StFetch;
                        end
                    end else if (imem_ack) begin
                        if (stall) begin
                            state_q <= StHold;
                        end else begin
                            fetched_pc_q  <= pc_q;
                            fetch_valid_q <= 1'b1;
                            pc_q          <= pc_inc;
                        end
                    end
                end
                default: state_q <= StBoot;
            endcase
        end
    end

    assign imem_req    = (state_q == StFetch);
    assign imem_addr   = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign fetched_pc  = fetched_pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the fetch rules.
module tb_pc_fetch_ctrl;

    localparam logic [11:0] RST_PC = 12'h000;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        jump;
    logic [11:0] jump_target;
    logic        branch_taken;
    logic [11:0] br_pc;
    logic [11:0] br_offset;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic        fetch_valid;
    logic [11:0] fetched_pc;

    int checks = 0;
    int errors = 0;

    // Reference model: boot countdown, accepted-but-undelivered flag, PC, last delivery
    int m_boot;
    bit m_pending;
    int m_pc;
    bit m_valid;
    int m_fpc;

    pc_fetch_ctrl #(
        .RESET_PC (RST_PC)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .stall        (stall),
        .jump         (jump),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .br_pc        (br_pc),
        .br_offset    (br_offset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .fetch_valid  (fetch_valid),
        .fetched_pc   (fetched_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit exp_req();
        return (m_boot == 0) && !m_pending;
    endfunction

    task automatic model_reset();
        m_boot    = 2;
        m_pending = 0;
        m_pc      = int'(RST_PC);
        m_valid   = 0;
        m_fpc     = int'(RST_PC);
    endtask

    // Advance one clock edge in both DUT and model, then settle 1 time unit
    task automatic tick();
        @(posedge clock);
        m_valid = 0;
        if (m_boot > 0) begin
            m_boot--;
        end else if (jump) begin
            m_pc      = int'(jump_target);
            m_pending = 0;
        end else if (branch_taken) begin
            m_pc      = (int'(br_pc) + 1 + int'(br_offset)) % 4096;
            m_pending = 0;
        end else if (m_pending || imem_ack) begin
            if (stall) begin
                m_pending = 1;
            end else begin
                m_valid   = 1;
                m_fpc     = m_pc;
                m_pc      = (m_pc + 1) % 4096;
                m_pending = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        stall        = 0;
        jump         = 0;
        jump_target  = '0;
        branch_taken = 0;
        br_pc        = '0;
        br_offset    = '0;
        imem_ack     = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        model_reset();
        #12;
        checks++;
        if ({imem_req, imem_addr, fetch_valid, fetched_pc} !== {1'b0, RST_PC, 1'b0, RST_PC}) begin
            errors++;
            $display("FAIL reset_state: req=%0b addr=%h valid=%0b fpc=%h want 0 %h 0 %h",
                     imem_req, imem_addr, fetch_valid, fetched_pc, RST_PC, RST_PC);
        end
        #1 reset_n = 1;
    endtask

    task automatic test_sequential();
        imem_ack = 1;
        stall    = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if ({imem_req, fetch_valid, fetched_pc} !== {exp_req(), m_valid, 12'(m_fpc)} ||
                (exp_req() && imem_addr !== 12'(m_pc))) begin
                errors++;
                $display("FAIL seq[%0d]: req=%0b addr=%h valid=%0b fpc=%h want %0b %h %0b %h",
                         i, imem_req, imem_addr, fetch_valid, fetched_pc,
                         exp_req(), 12'(m_pc), m_valid, 12'(m_fpc));
            end
            if (i == 2) begin
                checks++;
                if (fetch_valid !== 1'b1 || fetched_pc !== 12'h000 || imem_addr !== 12'h001) begin
                    errors++;
                    $display("FAIL seq_third_edge: valid=%0b fpc=%h addr=%h want 1 000 001",
                             fetch_valid, fetched_pc, imem_addr);
                end
            end
        end
    endtask

    task automatic test_wrap();
        imem_ack    = 0;
        jump        = 1;
        jump_target = 12'hFFF;
        tick();
        jump     = 0;
        imem_ack = 1;
        tick();
        checks++;
        if (fetch_valid !== 1'b1 || fetched_pc !== 12'hFFF || imem_addr !== 12'h000 ||
            imem_req !== 1'b1) begin
            errors++;
            $display("FAIL wrap: valid=%0b fpc=%h addr=%h req=%0b want 1 fff 000 1",
                     fetch_valid, fetched_pc, imem_addr, imem_req);
        end
        checks++;
        if (12'(m_pc) !== imem_addr || 12'(m_fpc) !== fetched_pc) begin
            errors++;
            $display("FAIL wrap_model: addr=%h fpc=%h want %h %h",
                     imem_addr, fetched_pc, 12'(m_pc), 12'(m_fpc));
        end
    endtask

    task automatic test_stall_hold();
        logic [11:0] held;
        int          pulses;
        held     = imem_addr;
        imem_ack = 1;
        stall    = 1;
        tick();
        imem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: req=%0b valid=%0b want 0 0", i, imem_req, fetch_valid);
            end
            if (i < 2) tick();
        end
        stall  = 0;
        pulses = 0;
        tick();
        checks++;
        if (fetch_valid !== 1'b1 || fetched_pc !== held || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: valid=%0b fpc=%h req=%0b want 1 %h 1",
                     fetch_valid, fetched_pc, imem_req, held);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (fetch_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL hold_single_pulse: extra pulses=%0d want 0", pulses);
        end
    endtask

    task automatic test_branch();
        imem_ack     = 1;
        stall        = 0;
        branch_taken = 1;
        br_pc        = 12'h010;
        br_offset    = 12'hFFC;
        tick();
        branch_taken = 0;
        checks++;
        if (imem_addr !== 12'h00D || imem_req !== 1'b1 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL branch: addr=%h req=%0b valid=%0b want 00d 1 0",
                     imem_addr, imem_req, fetch_valid);
        end
        tick();
        checks++;
        if (fetch_valid !== 1'b1 || fetched_pc !== 12'h00D || imem_addr !== 12'h00E) begin
            errors++;
            $display("FAIL branch_follow: valid=%0b fpc=%h addr=%h want 1 00d 00e",
                     fetch_valid, fetched_pc, imem_addr);
        end
    endtask

    task automatic test_jump_branch();
        imem_ack     = 1;
        jump         = 1;
        jump_target  = 12'h200;
        branch_taken = 1;
        br_pc        = 12'h050;
        br_offset    = 12'h004;
        tick();
        jump         = 0;
        branch_taken = 0;
        checks++;
        if (imem_addr !== 12'h200 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_priority: addr=%h valid=%0b want 200 0", imem_addr, fetch_valid);
        end
        stall = 1;
        tick();
        imem_ack    = 0;
        jump        = 1;
        jump_target = 12'h123;
        tick();
        jump = 0;
        checks++;
        if (imem_addr !== 12'h123 || imem_req !== 1'b1 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_in_stall: addr=%h req=%0b valid=%0b want 123 1 0",
                     imem_addr, imem_req, fetch_valid);
        end
        stall = 0;
    endtask

    task automatic test_async_reset();
        imem_ack = 0;
        stall    = 0;
        tick();
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: req=%0b want 1", imem_req);
        end
        #2 reset_n = 0;
        #1;
        model_reset();
        checks++;
        if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL areset_drop: req=%0b valid=%0b addr=%h want 0 0 %h",
                     imem_req, fetch_valid, imem_addr, RST_PC);
        end
        #1 reset_n = 1;
        imem_ack = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({imem_req, fetch_valid, fetched_pc} !== {exp_req(), m_valid, 12'(m_fpc)} ||
                (exp_req() && imem_addr !== 12'(m_pc))) begin
                errors++;
                $display("FAIL areset_restart[%0d]: req=%0b addr=%h valid=%0b fpc=%h want %0b %h %0b %h",
                         i, imem_req, imem_addr, fetch_valid, fetched_pc,
                         exp_req(), 12'(m_pc), m_valid, 12'(m_fpc));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall        = ($urandom_range(0, 9) < 3);
            imem_ack     = ($urandom_range(0, 1) == 1);
            jump         = ($urandom_range(0, 19) == 0);
            jump_target  = 12'($urandom);
            branch_taken = ($urandom_range(0, 11) == 0);
            br_pc        = 12'($urandom);
            br_offset    = 12'($urandom);
            tick();
            checks++;
            if ({imem_req, fetch_valid, fetched_pc} !== {exp_req(), m_valid, 12'(m_fpc)} ||
                (exp_req() && imem_addr !== 12'(m_pc))) begin
                errors++;
                $display("FAIL random[%0d]: req=%0b addr=%h valid=%0b fpc=%h want %0b %h %0b %h",
                         i, imem_req, imem_addr, fetch_valid, fetched_pc,
                         exp_req(), 12'(m_pc), m_valid, 12'(m_fpc));
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrap();
        test_stall_hold();
        test_branch();
        test_jump_branch();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and instruction-fetch controller for the 12-bit-address processor core. It holds the architectural PC, issues fetch requests to instruction memory over a req/ack handshake, and honours pipeline stalls. It redirects on jumps and taken branches, and delivers each fetched PC to the decode stage. All PC arithmetic uses the core's 12-bit carry-lookahead adder with carry-in tied low.

## Interface
- ADDR_W, 12, address width; fixed at 12 because the adder is 12 bits.
- RESET_PC, 12'h000, PC value loaded on reset.

- clock  in  1  single core clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  decode back-pressure; while high, no new PC is handed to decode.
- jump  in  1  one-cycle pulse; redirect to jump_target.
- jump_target  in  12  absolute jump address.
- branch_taken  in  1  one-cycle pulse; redirect to br_pc + 1 + br_offset.
- br_pc  in  12  PC of the branch instruction.
- br_offset  in  12  two's-complement branch offset.
- imem_req  out  1  fetch request; held high until acknowledged.
- imem_addr  out  12  fetch address; equals pc while imem_req is high.
- imem_ack  in  1  memory acceptance; may be asserted in the same cycle as imem_req.
- fetch_valid  out  1  one-cycle pulse marking a new fetched_pc for decode.
- fetched_pc  out  12  PC of the instruction just delivered.

## Operation
- The FSM has three states.
  - BOOT: imem_req=0. Exits to FETCH after exactly one cycle. jump and branch_taken are ignored in BOOT.
  - FETCH: imem_req=1, imem_addr=pc.
    - imem_ack && !stall: fetched_pc<=pc, fetch_valid<=1, pc<=pc+1; stay in FETCH.
    - imem_ack && stall: stay at the same pc; go to HOLD.
    - no ack: hold pc and the request.
  - HOLD: imem_req=0; the instruction is accepted but not yet delivered.
    - !stall: fetched_pc<=pc, fetch_valid<=1, pc<=pc+1; go to FETCH.
- Redirect priority is jump > branch_taken > sequential.
- A redirect in FETCH or HOLD does all of the following in that cycle:
  - pc<=target;
  - state<=FETCH;
  - fetch_valid<=0 (squash);
  - discards any ack received that cycle.
- Redirect also overrides stall.
- Arithmetic is modulo 2^12 with carry-out dropped: pc+1 of 12'hFFF is 12'h000.
- Branch target: adder A computes br_pc+1; adder B adds br_offset to that result. Sign handling comes from the modulo wrap, so no explicit sign extension is needed.
- The incrementer is a separate adder instance computing pc+1, so the two add paths never share hardware.

## Timing
- Reset values: state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, fetch_valid=0, fetched_pc=RESET_PC.
- Reset is asynchronous: asserting reset_n low mid-fetch drops imem_req immediately. No fetch_valid is produced for the aborted fetch.
- After reset_n deasserts, the first imem_req appears on the second rising edge: BOOT for one cycle, then FETCH.
- Ack-to-delivery latency: fetch_valid rises on the edge after imem_ack, or on the edge after stall falls when the FSM is in HOLD.
- Peak throughput: one fetch_valid per cycle when imem_ack is tied high and stall is low.
- fetch_valid is registered and is never high on two cycles for the same fetched_pc.
- imem_req and imem_addr are decoded from registered state and pc, with no combinational path from imem_ack.
- jump and branch_taken are sampled on the edge; the redirect target appears on imem_addr the next cycle.

## Structure
- Shared package holds:
  - ADDR_W;
  - the state encoding (BOOT=2'd0, FETCH=2'd1, HOLD=2'd2);
  - RESET_PC default.
- Sub-module: cla_twelve, the existing 12-bit CLA with carry-in tied to 0. It is instantiated three times:
  - pc+1;
  - br_pc+1;
  - (br_pc+1)+br_offset.
- Redirect muxing and the FSM live in pc_fetch_ctrl itself. There is no other sub-module.

## Test plan
- Reset release with imem_ack tied 1 and stall 0 → imem_addr sequence 000, 001, 002, …; fetch_valid high every cycle starting on the third edge after release.
- pc=12'hFFF, ack → fetched_pc=FFF, next imem_addr=000.
- Ack while stall=1 for 3 cycles → FSM in HOLD with imem_req=0 for 3 cycles; after stall falls, a single fetch_valid with the held pc.
- branch_taken with br_pc=12'h010, br_offset=12'hFFC (−4) → imem_addr=00D the next cycle; the in-flight ack in that cycle is squashed, so no fetch_valid follows it.
- jump (target 12'h200) and branch_taken in the same cycle → imem_addr=200; redirect during stall is also taken.
- reset_n pulsed low while imem_req=1 and before ack → imem_req drops asynchronously; after release the sequence restarts at RESET_PC with no stale fetch_valid.
